// File: rtl/fpu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module : fpu_operand_loader
// Brief  : Two-stage valid/ready loader turning i32/u32/fp32 register data
//          into a signed Q(FRAC_BITS) FPU operand with ovf/nan/err flags.
// Option : FPU_LOADER_ROUND_NEAREST_EN selects round-to-nearest-even on fp32
//          right shifts (default build truncates toward zero).
// Rev    : 1.0
// ============================================================================
module fpu_operand_loader #(
  parameter int Q_WIDTH   = 64,
  parameter int FRAC_BITS = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_fmt,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Q_WIDTH-1:0] out_q,
  output logic               out_ovf,
  output logic               out_nan,
  output logic               out_err
);

  localparam int SHIFT_W = 12;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_NORM = 3'd1;
  localparam logic [2:0] CLS_INF  = 3'd2;
  localparam logic [2:0] CLS_NAN  = 3'd3;
  localparam logic [2:0] CLS_ERR  = 3'd4;

  localparam logic signed [SHIFT_W-1:0] C_EXP_BIAS   = SHIFT_W'(127);
  localparam logic signed [SHIFT_W-1:0] C_OVF_EXP    = SHIFT_W'(Q_WIDTH - 1 - FRAC_BITS);
  localparam logic signed [SHIFT_W-1:0] C_FRAC_SHIFT = SHIFT_W'(FRAC_BITS);
  localparam logic signed [SHIFT_W-1:0] C_MANT_ADJ   = SHIFT_W'(FRAC_BITS - 23);
  localparam logic        [SHIFT_W-1:0] C_QW_U       = SHIFT_W'(Q_WIDTH);
  localparam logic        [Q_WIDTH-1:0] C_POS_MAX    = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic        [Q_WIDTH-1:0] C_NEG_MAX    = {1'b1, {(Q_WIDTH-1){1'b0}}};

  // Stage 1 state
  logic                      s1_valid_q;
  logic                      s1_sign_q,  s1_sign_d;
  logic [31:0]               s1_mag_q,   s1_mag_d;
  logic signed [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  logic [2:0]                s1_cls_q,   s1_cls_d;

  // Stage 2 state
  logic               out_valid_q;
  logic [Q_WIDTH-1:0] out_q_q;
  logic               out_ovf_q, out_nan_q, out_err_q;

  logic w_s1_adv;
  logic w_in_ready;

  assign w_s1_adv   = !out_valid_q || out_ready;
  assign w_in_ready = !s1_valid_q || w_s1_adv;

  // ---------------------------------------------------------------- stage 1
  logic [7:0]                w_exp;
  logic [22:0]               w_frac;
  logic signed [SHIFT_W-1:0] w_e;

  assign w_exp  = in_data[30:23];
  assign w_frac = in_data[22:0];
  assign w_e    = $signed({{(SHIFT_W-8){1'b0}}, w_exp}) - C_EXP_BIAS;

  // Integers are carried as sign + magnitude so all formats share one shifter.
  always_comb begin
    s1_sign_d  = 1'b0;
    s1_mag_d   = in_data;
    s1_shift_d = C_FRAC_SHIFT;
    s1_cls_d   = CLS_NORM;
    case (in_fmt)
      2'b00: begin
        s1_sign_d = in_data[31];
        if (in_data[31]) s1_mag_d = ~in_data + 32'd1;
      end
      2'b01: begin
        s1_mag_d = in_data;
      end
      2'b10: begin
        s1_sign_d  = in_data[31];
        s1_mag_d   = {8'd0, 1'b1, w_frac};
        s1_shift_d = w_e + C_MANT_ADJ;
        if (w_exp == 8'h00)      s1_cls_d = CLS_ZERO;
        else if (w_exp == 8'hFF) s1_cls_d = (w_frac == 23'd0) ? CLS_INF : CLS_NAN;
        else if (w_e >= C_OVF_EXP) s1_cls_d = CLS_INF;
      end
      default: s1_cls_d = CLS_ERR;
    endcase
  end

  // ---------------------------------------------------------------- stage 2
  logic                      w_left;
  logic [SHIFT_W-1:0]        w_lamt, w_ramt;
  logic [Q_WIDTH-1:0]        w_mag_ext, w_trunc, w_abs, w_q;
  logic                      w_ovf, w_nan, w_err;

  assign w_mag_ext = {{(Q_WIDTH-32){1'b0}}, s1_mag_q};
  assign w_left    = !s1_shift_q[SHIFT_W-1];
  assign w_lamt    = s1_shift_q;
  assign w_ramt    = -s1_shift_q;

  always_comb begin
    w_trunc = '0;
    if (w_left)               w_trunc = w_mag_ext << w_lamt;
    else if (w_ramt < C_QW_U) w_trunc = w_mag_ext >> w_ramt;
  end

`ifdef FPU_LOADER_ROUND_NEAREST_EN
  logic [Q_WIDTH-1:0] w_half_mask, w_sticky_mask;
  logic               w_round_up;

  always_comb begin
    w_half_mask   = {{(Q_WIDTH-1){1'b0}}, 1'b1} << (w_ramt - SHIFT_W'(1));
    w_sticky_mask = w_half_mask - {{(Q_WIDTH-1){1'b0}}, 1'b1};
    w_round_up    = !w_left && (w_ramt < C_QW_U) && (|(w_mag_ext & w_half_mask)) &&
                    ((|(w_mag_ext & w_sticky_mask)) || w_trunc[0]);
  end

  assign w_abs = w_trunc + {{(Q_WIDTH-1){1'b0}}, w_round_up};
`else
  assign w_abs = w_trunc;
`endif

  // A set top bit in the magnitude means a round-up crossed the positive maximum.
  always_comb begin
    w_q   = '0;
    w_ovf = 1'b0;
    w_nan = 1'b0;
    w_err = 1'b0;
    case (s1_cls_q)
      CLS_NORM: begin
        if (w_abs[Q_WIDTH-1]) begin
          w_q   = s1_sign_q ? C_NEG_MAX : C_POS_MAX;
          w_ovf = 1'b1;
        end else begin
          w_q = s1_sign_q ? -w_abs : w_abs;
        end
      end
      CLS_INF: begin
        w_q   = s1_sign_q ? C_NEG_MAX : C_POS_MAX;
        w_ovf = 1'b1;
      end
      CLS_NAN: w_nan = 1'b1;
      CLS_ERR: w_err = 1'b1;
      default: w_q = '0;
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_shift_q  <= '0;
      s1_cls_q    <= CLS_ZERO;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_ovf_q   <= 1'b0;
      out_nan_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      if (w_in_ready) s1_valid_q <= in_valid;
      if (in_valid && w_in_ready) begin
        s1_sign_q  <= s1_sign_d;
        s1_mag_q   <= s1_mag_d;
        s1_shift_q <= s1_shift_d;
        s1_cls_q   <= s1_cls_d;
      end
      if (w_s1_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_q_q   <= w_q;
          out_ovf_q <= w_ovf;
          out_nan_q <= w_nan;
          out_err_q <= w_err;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_ovf   = out_ovf_q;
  assign out_nan   = out_nan_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_fpu_operand_loader
// Brief  : Directed self-checking bench for fpu_operand_loader.
// Rev    : 1.0
// ============================================================================
module tb_fpu_operand_loader;

  localparam int QW = 64;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    in_fmt    = 2'b00;
  logic [31:0]   in_data   = 32'd0;
  logic          in_ready, out_valid, out_ovf, out_nan, out_err;
  logic [QW-1:0] out_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_operand_loader #(.Q_WIDTH(QW), .FRAC_BITS(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_fmt   (in_fmt),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_ovf  (out_ovf),
    .out_nan  (out_nan),
    .out_err  (out_err)
  );

  // Pushes one operand with out_ready high and returns what appears at the output.
  task automatic convert(input logic [1:0] f, input logic [31:0] d, output logic v,
                         output logic [QW-1:0] q, output logic [2:0] fl, output int lat);
    int n;
    in_fmt = f; in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    v = out_valid; q = out_q; fl = {out_ovf, out_nan, out_err};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_q !== '0 || {out_ovf, out_nan, out_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got v=%b q=%h flags=%b, expected v=0 q=0 flags=000",
               out_valid, out_q, {out_ovf, out_nan, out_err});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_i32();
    logic [31:0]   din [3] = '{32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [QW-1:0] eq  [3] = '{64'hFFFF_FFFF_FFFD_8000, 64'h0000_3FFF_FFFF_8000,
                               64'hFFFF_C000_0000_0000};
    logic v; logic [QW-1:0] q; logic [2:0] fl; int lat;
    for (int i = 0; i < 3; i++) begin
      convert(2'b00, din[i], v, q, fl, lat);
      checks++;
      if (v !== 1'b1 || q !== eq[i] || fl !== 3'b000) begin
        errors++;
        $display("FAIL i32[%0d] in=%h: got v=%b q=%h flags=%b, expected v=1 q=%h flags=000",
                 i, din[i], v, q, fl, eq[i]);
      end
      if (i == 0) begin
        checks++;
        if (lat != 2) begin
          errors++;
          $display("FAIL latency: got %0d cycles, expected 2", lat);
        end
      end
    end
  endtask

  task automatic test_u32();
    logic [31:0]   din [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [QW-1:0] eq  [2] = '{64'h0000_7FFF_FFFF_8000, 64'h0000_4000_0000_0000};
    logic v; logic [QW-1:0] q; logic [2:0] fl; int lat;
    for (int i = 0; i < 2; i++) begin
      convert(2'b01, din[i], v, q, fl, lat);
      checks++;
      if (v !== 1'b1 || q !== eq[i] || fl !== 3'b000) begin
        errors++;
        $display("FAIL u32[%0d] in=%h: got v=%b q=%h flags=%b, expected v=1 q=%h flags=000",
                 i, din[i], v, q, fl, eq[i]);
      end
    end
  endtask

  task automatic test_fp32();
    // flags are {ovf, nan, err}
    logic [31:0]   din [13] = '{32'hBF80_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'h3E80_0000,
                                32'h0000_0000, 32'h0000_0001, 32'h0080_0000, 32'h5700_0000,
                                32'h5780_0000, 32'hD780_0000, 32'h60AD_78EC, 32'hFF80_0000,
                                32'h7F80_0000};
    logic [QW-1:0] eq  [13] = '{64'hFFFF_FFFF_FFFF_8000, 64'h0000_0000_0000_C000,
                                64'h0000_0000_0000_8000, 64'h0000_0000_0000_2000,
                                64'h0, 64'h0, 64'h0, 64'h4000_0000_0000_0000,
                                64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                64'h7FFF_FFFF_FFFF_FFFF};
    logic [2:0]    ef  [13] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic v; logic [QW-1:0] q; logic [2:0] fl; int lat;
    for (int i = 0; i < 13; i++) begin
      convert(2'b10, din[i], v, q, fl, lat);
      checks++;
      if (v !== 1'b1 || q !== eq[i] || fl !== ef[i]) begin
        errors++;
        $display("FAIL fp32[%0d] in=%h: got v=%b q=%h flags=%b, expected v=1 q=%h flags=%b",
                 i, din[i], v, q, fl, eq[i], ef[i]);
      end
    end
  endtask

  task automatic test_nan_err();
    logic v; logic [QW-1:0] q; logic [2:0] fl; int lat;
    convert(2'b10, 32'h7FC0_0000, v, q, fl, lat);
    checks++;
    if (v !== 1'b1 || q !== '0 || fl !== 3'b010) begin
      errors++;
      $display("FAIL nan_pos: got v=%b q=%h flags=%b, expected v=1 q=0 flags=010", v, q, fl);
    end
    convert(2'b10, 32'hFFC0_0001, v, q, fl, lat);
    checks++;
    if (v !== 1'b1 || q !== '0 || fl !== 3'b010) begin
      errors++;
      $display("FAIL nan_neg: got v=%b q=%h flags=%b, expected v=1 q=0 flags=010", v, q, fl);
    end
    convert(2'b11, 32'h1234_5678, v, q, fl, lat);
    checks++;
    if (v !== 1'b1 || q !== '0 || fl !== 3'b001) begin
      errors++;
      $display("FAIL reserved_fmt: got v=%b q=%h flags=%b, expected v=1 q=0 flags=001", v, q, fl);
    end
  endtask

  task automatic test_rounding();
    logic [31:0]   din [4] = '{32'h37C0_0000, 32'h3780_0000, 32'h3840_0000, 32'hB7C0_0000};
`ifdef FPU_LOADER_ROUND_NEAREST_EN
    logic [QW-1:0] eq  [4] = '{64'h1, 64'h0, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF};
`else
    logic [QW-1:0] eq  [4] = '{64'h0, 64'h0, 64'h1, 64'h0};
`endif
    logic v; logic [QW-1:0] q; logic [2:0] fl; int lat;
    for (int i = 0; i < 4; i++) begin
      convert(2'b10, din[i], v, q, fl, lat);
      checks++;
      if (v !== 1'b1 || q !== eq[i] || fl !== 3'b000) begin
        errors++;
        $display("FAIL round[%0d] in=%h: got v=%b q=%h flags=%b, expected v=1 q=%h flags=000",
                 i, din[i], v, q, fl, eq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    logic saw_low = 1'b0;
    logic acc;
    logic [QW-1:0] expq;
    for (int c = 1; c <= 20; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 4);
      in_fmt    = 2'b00;
      in_data   = 32'(sent + 1);
      #1;
      acc = in_valid && in_ready;
      if (!in_ready) saw_low = 1'b1;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_q !== 64'h8000) begin
          errors++;
          $display("FAIL stall_hold c=%0d: got v=%b q=%h, expected v=1 q=0000000000008000",
                   c, out_valid, out_q);
        end
      end
      if (out_valid && out_ready) begin
        expq = 64'(got + 1) << 15;
        checks++;
        if (out_q !== expq || got >= 4) begin
          errors++;
          $display("FAIL b2b_order #%0d: got q=%h, expected q=%h", got, out_q, expq);
        end
        got++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || sent != 4) begin
      errors++;
      $display("FAIL b2b_count: got outputs=%0d accepted=%0d, expected 4 and 4", got, sent);
    end
    checks++;
    if (saw_low !== 1'b1) begin
      errors++;
      $display("FAIL b2b_backpressure: got in_ready low seen=%b, expected 1", saw_low);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 2'b00; in_data = 32'd7;
    @(posedge clk); #1;
    in_data = 32'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midflight_setup: got v=%b in_ready=%b, expected v=1 in_ready=0",
               out_valid, in_ready);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_q !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b q=%h, expected v=0 q=0", out_valid, out_q);
    end
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_after_reset cyc=%0d: got v=%b q=%h, expected v=0", i, out_valid, out_q);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i32();
    test_u32();
    test_fp32();
    test_nan_err();
    test_rounding();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_operand_loader.md
Name: fpu_operand_loader

Overview:
- Converts a 32-bit register-file read value into the FPU's 64-bit Q15 fixed-point operand format; the inverse of the register write-back conversion path.
- Sits between register read and FPU operand input.
- Two-stage valid/ready pipeline: stage 1 unpacks, stage 2 shifts, negates and saturates.
- Reports saturation and NaN per operand.

Parameters:
- Q_WIDTH, 64, width of the fixed-point operand; two's complement.
- FRAC_BITS, 15, number of fractional bits; value = q / 2^FRAC_BITS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all pipeline state.
- in_valid  in  1  input operand present.
- in_ready  out  1  loader accepts input this cycle.
- in_fmt  in  2  source format: 2'b00 i32, 2'b01 u32, 2'b10 fp32, 2'b11 reserved.
- in_data  in  32  register read data.
- out_valid  out  1  converted operand present.
- out_ready  in  1  FPU accepts operand.
- out_q  out  Q_WIDTH  Q15 operand.
- out_ovf  out  1  result saturated (fp32 overflow or Inf).
- out_nan  out  1  input was fp32 NaN.
- out_err  out  1  reserved in_fmt was used.

Behaviour:
- Reset:
  - Asynchronous and active-high. Reset mid-transfer drops all in-flight operands.
  - s1_valid=0, out_valid=0, out_q=0, out_ovf=0, out_nan=0, out_err=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Handshake:
  - A transfer occurs on a clock edge when valid and ready are both high.
  - in_ready = !s1_valid || s1_adv, where s1_adv = (!out_valid || out_ready).
  - Stage 2 loads from stage 1 when s1_valid && s1_adv.
  - out_valid clears on an out_ready transfer if there is no new stage-1 data.
  - While out_valid && !out_ready: out_q and all flags stay stable.
- Latency and throughput: 2 cycles from input acceptance to out_valid with out_ready held high; 1 operand per cycle sustained; no bubbles are inserted under continuous flow.
- Stage 1 registers:
  - sign, magnitude (up to 32 bits), shift amount (signed) and class (zero, normal, inf, nan, err).
- i32 conversion:
  - Sign-extend to Q_WIDTH, then shift left by FRAC_BITS. This is exact; no flags.
- u32 conversion:
  - Zero-extend, then shift left by FRAC_BITS. This is exact.
- fp32 conversion:
  - Unbiased exponent e = exp-127; mantissa m = {1,frac} (24 bits).
  - |q| = m shifted by (e-23+FRAC_BITS): left when non-negative, right when negative.
  - Right shifts truncate the magnitude (toward zero).
  - Apply sign by two's complement negation after the shift.
  - exp==0 (zero or denormal): result 0, no flags.
  - Shifts of Q_WIDTH or more to the right give 0.
  - Overflow when e >= Q_WIDTH-1-FRAC_BITS (48 at defaults):
    - Saturate to 0x7FFF_FFFF_FFFF_FFFF for positive inputs, 0x8000_0000_0000_0000 for negative.
    - Set out_ovf.
  - Inf: saturate by sign and set out_ovf.
  - NaN: out_q=0, out_nan=1.
- Reserved format: out_q=0, out_err=1.
- Flags travel with their operand and are valid only while out_valid=1.
- Simultaneous accept and drain in the same cycle is legal in both stages.

Optional Feature:
- Macro FPU_LOADER_ROUND_NEAREST_EN.
  - Defined: fp32 right shifts round to nearest, ties to even, on the magnitude before negation.
  - A round-up that crosses the positive maximum saturates and sets out_ovf.
  - Not defined: truncation toward zero, as specified above.
- Either way, latency, the handshake and the i32/u32 paths are unchanged.

Test Plan:
- i32 0xFFFFFFFB (-5), out_ready=1 -> 2 cycles later out_q=0xFFFF_FFFF_FFFD_8000, all flags 0.
- u32 0xFFFFFFFF -> out_q=0x0000_7FFF_FFFF_8000; fp32 0xBF800000 (-1.0) -> 0xFFFF_FFFF_FFFF_8000; fp32 0x3FC00000 (1.5) -> 0x0000_0000_0000_C000.
- fp32 0x60AD78EC (1e20) -> 0x7FFF_FFFF_FFFF_FFFF, out_ovf=1; 0xFF800000 (-Inf) -> 0x8000_0000_0000_0000, out_ovf=1; 0x7FC00000 -> 0, out_nan=1; in_fmt=2'b11 -> 0, out_err=1.
- fp32 0x37C00000 (0.75 LSB):
  - Without the macro -> out_q=0.
  - With FPU_LOADER_ROUND_NEAREST_EN -> out_q=1.
  - 0x37800000 (exact half LSB) -> 0 in both builds.
- Back-to-back i32 values 1,2,3,4 with out_ready low in cycles 3-5:
  - in_ready drops after two operands are held.
  - out_q stays 0x8000 while stalled.
  - Outputs arrive in order 0x8000, 0x10000, 0x18000, 0x20000, with no loss or duplication.
- reset asserted while two operands are in flight -> out_valid=0 and out_q=0 immediately (asynchronous); no stale output after reset is released.
